// File: rtl/cc_seq_ctrl.sv
// Purpose: sequences queued swap actions through SWAP/SCAN/CLEAR/DROP datapath commands and accumulates a score.
// Latency: first dp_req two cycles after in_valid_2 falls; out_valid pulses one cycle after the queue drains.
// Backpressure: each command holds dp_req/dp_op/dp_pos/dp_dir stable until dp_ack; stray dp_ack is ignored.
module cc_seq_ctrl #(
  parameter int MAX_ACT     = 10,
  parameter int MAX_CASCADE = 8,
  parameter int SCORE_W     = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_2,
  input  logic [1:0]         in_action,
  input  logic [5:0]         in_starting_pos,
  output logic               dp_req,
  output logic [1:0]         dp_op,
  output logic [5:0]         dp_pos,
  output logic [1:0]         dp_dir,
  input  logic               dp_ack,
  input  logic [3:0]         dp_hits,
  output logic               out_valid,
  output logic [SCORE_W-1:0] out_score
);

  localparam int CNT_W = $clog2(MAX_ACT + 1);
  localparam int CAS_W = $clog2(MAX_CASCADE + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_NEXT, S_SWAP, S_SCAN, S_CLEAR, S_DROP, S_DONE
  } state_t;

  state_t state, state_nxt;

  // Only legal moves are stored; seen_cnt still counts every captured entry so
  // the MAX_ACT limit applies to the raw stream, while NEXT never spends
  // cycles on moves that would leave the board.
  logic [7:0]         fifo_mem [MAX_ACT];
  logic [CNT_W-1:0]   seen_cnt;
  logic [CNT_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]   rd_idx;
  logic [5:0]         cur_pos;
  logic [1:0]         cur_dir;
  logic [CAS_W-1:0]   cas_cnt;
  logic [SCORE_W-1:0] score;

  logic               capture;
  logic               accept;
  logic               in_legal;
  logic               fifo_empty;
  logic               ack;
  logic               cmd_nxt;
  logic [7:0]         head;
  logic [2:0]         in_row;
  logic [2:0]         in_col;
  logic [SCORE_W:0]   score_sum;

  // Board-edge legality of the incoming move and capture qualifiers.
  always_comb begin
    in_row   = in_starting_pos[5:3];
    in_col   = in_starting_pos[2:0];
    in_legal = (in_row <= 3'd5) && (in_col <= 3'd5);
    case (in_action)
      2'b00:   if (in_row == 3'd0) in_legal = 1'b0;
      2'b01:   if (in_row == 3'd5) in_legal = 1'b0;
      2'b10:   if (in_col == 3'd0) in_legal = 1'b0;
      default: if (in_col == 3'd5) in_legal = 1'b0;
    endcase
    capture    = in_valid_2 && (state == S_IDLE || state == S_LOAD);
    accept     = capture && (seen_cnt < CNT_W'(MAX_ACT));
    fifo_empty = (rd_idx == wr_cnt);
    head       = fifo_mem[rd_idx];
    ack        = dp_req && dp_ack;
    score_sum  = {1'b0, score} + {{(SCORE_W-3){1'b0}}, dp_hits};
  end

  // Next-state selection; commands advance only on an acknowledged request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid_2) state_nxt = S_LOAD;
      S_LOAD:  if (!in_valid_2) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = fifo_empty ? S_DONE : S_SWAP;
      S_SWAP:  if (ack) state_nxt = S_SCAN;
      S_SCAN:  if (ack) state_nxt = (dp_hits == 4'd0) ? S_NEXT : S_CLEAR;
      S_CLEAR: if (ack) state_nxt = S_DROP;
      S_DROP:  if (ack) state_nxt = (cas_cnt == CAS_W'(MAX_CASCADE)) ? S_NEXT : S_SCAN;
      default: state_nxt = S_IDLE;
    endcase
    cmd_nxt = (state_nxt == S_SWAP) || (state_nxt == S_SCAN) ||
              (state_nxt == S_CLEAR) || (state_nxt == S_DROP);
  end

  // Command fields decode straight from state, so they cannot move mid-request.
  always_comb begin
    dp_op     = 2'b00;
    dp_pos    = 6'd0;
    dp_dir    = 2'b00;
    out_valid = 1'b0;
    out_score = '0;
    case (state)
      S_SWAP:  begin dp_pos = cur_pos; dp_dir = cur_dir; end
      S_SCAN:  dp_op = 2'b01;
      S_CLEAR: dp_op = 2'b10;
      S_DROP:  dp_op = 2'b11;
      S_DONE:  begin out_valid = 1'b1; out_score = score; end
      default: ;
    endcase
  end

  // State register and request flag; an ack drops dp_req for one cycle so the
  // following command is seen as a fresh rising request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      dp_req <= 1'b0;
    end else begin
      state  <= state_nxt;
      dp_req <= cmd_nxt && !ack;
    end
  end

  // Action storage; contents need no reset because the counters gate every read.
  always_ff @(posedge clk) begin
    if (accept && in_legal) fifo_mem[wr_cnt] <= {in_action, in_starting_pos};
  end

  // Queue counters and the popped action; everything is cleared on the way back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_cnt <= '0;
      wr_cnt   <= '0;
      rd_idx   <= '0;
      cur_pos  <= '0;
      cur_dir  <= '0;
    end else if (state == S_DONE) begin
      seen_cnt <= '0;
      wr_cnt   <= '0;
      rd_idx   <= '0;
      cur_pos  <= '0;
      cur_dir  <= '0;
    end else begin
      if (accept) begin
        seen_cnt <= seen_cnt + CNT_W'(1);
        if (in_legal) wr_cnt <= wr_cnt + CNT_W'(1);
      end
      if (state == S_NEXT && !fifo_empty) begin
        rd_idx  <= rd_idx + CNT_W'(1);
        cur_pos <= head[5:0];
        cur_dir <= head[7:6];
      end
    end
  end

  // Saturating score and per-action cascade round counter; dp_hits matters only on a SCAN ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score   <= '0;
      cas_cnt <= '0;
    end else if (state == S_DONE) begin
      score   <= '0;
      cas_cnt <= '0;
    end else if (state == S_SWAP && ack) begin
      cas_cnt <= '0;
    end else if (state == S_SCAN && ack && dp_hits != 4'd0) begin
      score   <= score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
      cas_cnt <= cas_cnt + CAS_W'(1);
    end
  end

endmodule
